// File: rtl/apr_pkg.sv
// apr_pkg: shared field positions, flag-write modes and priority decode for the APR controller
package apr_pkg;

    localparam int APR_FLAGLSB    = 31;
    localparam int APR_TRAPEN_BIT = 22;
    localparam int APR_PAGEEN_BIT = 23;

    localparam int APR_WR_LOAD = 0;
    localparam int APR_WR_W1C  = 1;

    localparam int APR_PRI_MAXW = 16;

    // One-hot request vector for npri levels: level 1 is the MSB, level 0 means no request,
    // levels above npri saturate to npri.
    function automatic logic [APR_PRI_MAXW-1:0] apr_pri_onehot(input int pri, input int npri);
        int e;
        e = (pri > npri) ? npri : pri;
        return (e != 0) ? (APR_PRI_MAXW'(1) << (npri - e)) : '0;
    endfunction

endpackage

// File: rtl/apr_interval_timer.sv
// apr_interval_timer: reloadable down-counter that pulses expire_o on the 1 -> 0 tick
module apr_interval_timer #(
    parameter int TMRW = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clken_i,
    input  logic            wr_i,
    input  logic [TMRW-1:0] val_i,
    input  logic            tick_i,
    output logic            expire_o
);

    logic [TMRW-1:0] count_q, count_d, reload_q, reload_d;

    assign expire_o = clken_i && tick_i && !wr_i && count_q == TMRW'(1);

    // A write overrides any tick; expiry reloads in the same cycle, count 0 stays idle.
    always_comb begin
        reload_d = wr_i ? val_i : reload_q;
        count_d  = wr_i ? val_i
                 : (tick_i && count_q != '0) ? ((count_q == TMRW'(1)) ? reload_q : count_q - TMRW'(1))
                 : count_q;
    end

    // Counter and reload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            reload_q <= '0;
        end else if (clken_i) begin
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

endmodule

// File: rtl/apr_intr_ctrl.sv
// apr_intr_ctrl: sticky APR flags, enable mask, software interrupt and registered one-hot request
module apr_intr_ctrl
    import apr_pkg::*;
#(
    parameter int                NFLAGS   = 8,
    parameter int                FLAGLSB  = APR_FLAGLSB,
    parameter int                NPRI     = 7,
    parameter logic [NFLAGS-1:0] EDGEMASK = '0,
    parameter int                W1CMODE  = APR_WR_LOAD,
    parameter int                TMRW     = 12,
    parameter int                TMRFLAG  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic [0:35]       dp,
    input  logic              wrFLAGS,
    input  logic              wrENABLE,
    input  logic              wrTIMER,
    input  logic              tmrTICK,
    input  logic [NFLAGS-1:0] setREQ,
    output logic [0:35]       aprFLAGS,
    output logic              aprINTREQ,
    output logic [1:NPRI]     aprINTR
);

    localparam int PW = $clog2(NPRI + 1);

    logic [NFLAGS-1:0] flags_q, flags_d, enable_q, enable_d, prev_q, set, dpf;
    logic              swint_q, swint_d, trapen_q, trapen_d, pageen_q, pageen_d;
    logic [PW-1:0]     pri_q, pri_d;
    logic [1:NPRI]     intr_q, intr_d;
    logic              expire;
    logic              unused_dp;

    assign unused_dp = ^dp;

    apr_interval_timer #(.TMRW(TMRW)) u_tmr (
        .clk      (clk),
        .rst_n    (rst),
        .clken_i  (clken),
        .wr_i     (wrTIMER),
        .val_i    (dp[36-TMRW:35]),
        .tick_i   (tmrTICK),
        .expire_o (expire)
    );

    for (genvar i = 0; i < NFLAGS; i++) begin : g_flag
        assign dpf[i] = dp[FLAGLSB-i];
        assign set[i] = (EDGEMASK[i] ? (setREQ[i] & ~prev_q[i]) : setREQ[i]) | (expire && (i == TMRFLAG));
    end

    for (genvar k = 0; k < 36; k++) begin : g_word
        if (k == APR_TRAPEN_BIT) begin : g_tp
            assign aprFLAGS[k] = trapen_q;
        end else if (k == APR_PAGEEN_BIT) begin : g_pg
            assign aprFLAGS[k] = pageen_q;
        end else if (k <= FLAGLSB && FLAGLSB - k < NFLAGS) begin : g_fl
            assign aprFLAGS[k] = flags_q[FLAGLSB-k];
        end else if (k == FLAGLSB + 1) begin : g_rq
            assign aprFLAGS[k] = aprINTREQ;
        end else begin : g_const
            assign aprFLAGS[k] = (k >= FLAGLSB + 2) ? 1'b1 : 1'b0;
        end
    end

    assign aprINTREQ = |(flags_q & enable_q) | swint_q;
    assign aprINTR   = intr_q;

    // Next state: hardware sets dominate software flag writes; enable fields load together.
    always_comb begin
        flags_d  = set | (wrFLAGS ? ((W1CMODE == APR_WR_W1C) ? (flags_q & ~dpf) : dpf) : flags_q);
        enable_d = wrENABLE ? dpf : enable_q;
        swint_d  = wrENABLE ? dp[FLAGLSB+1] : swint_q;
        trapen_d = wrENABLE ? dp[APR_TRAPEN_BIT] : trapen_q;
        pageen_d = wrENABLE ? dp[APR_PAGEEN_BIT] : pageen_q;
        pri_d    = wrENABLE ? dp[36-PW:35] : pri_q;
        intr_d   = aprINTREQ ? NPRI'(apr_pri_onehot(int'(pri_q), NPRI)) : '0;
    end

    // State registers, including the edge history and the registered request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q  <= '0;
            enable_q <= '0;
            prev_q   <= '0;
            swint_q  <= 1'b0;
            trapen_q <= 1'b0;
            pageen_q <= 1'b0;
            pri_q    <= '0;
            intr_q   <= '0;
        end else if (clken) begin
            flags_q  <= flags_d;
            enable_q <= enable_d;
            prev_q   <= setREQ;
            swint_q  <= swint_d;
            trapen_q <= trapen_d;
            pageen_q <= pageen_d;
            pri_q    <= pri_d;
            intr_q   <= intr_d;
        end
    end

endmodule

// File: tb/tb_apr_intr_ctrl.sv
// tb_apr_intr_ctrl: scoreboard bench for two controller builds (load-mode and write-1-clear mode)
module tb_apr_intr_ctrl;

    logic        clk = 1'b0, rst = 1'b0, clken = 1'b1;
    logic        wrFLAGS = 1'b0, wrENABLE = 1'b0, wrTIMER = 1'b0, tmrTICK = 1'b0;
    logic [0:35] dp = '0;
    logic [7:0]  setREQ = '0;
    logic [0:35] f0, f1;
    logic        r0, r1;
    logic [1:7]  i0, i1;

    typedef struct {
        string       nm;
        bit          d;
        logic [43:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [43:0] o;
    int          nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    apr_intr_ctrl #(.NFLAGS(8), .FLAGLSB(31), .NPRI(7), .EDGEMASK(8'h01), .W1CMODE(0), .TMRW(12), .TMRFLAG(6)) d0 (
        .clk(clk), .rst(rst), .clken(clken), .dp(dp), .wrFLAGS(wrFLAGS), .wrENABLE(wrENABLE),
        .wrTIMER(wrTIMER), .tmrTICK(tmrTICK), .setREQ(setREQ),
        .aprFLAGS(f0), .aprINTREQ(r0), .aprINTR(i0)
    );

    apr_intr_ctrl #(.NFLAGS(8), .FLAGLSB(31), .NPRI(7), .EDGEMASK(8'h01), .W1CMODE(1), .TMRW(12), .TMRFLAG(6)) d1 (
        .clk(clk), .rst(rst), .clken(clken), .dp(dp), .wrFLAGS(wrFLAGS), .wrENABLE(wrENABLE),
        .wrTIMER(wrTIMER), .tmrTICK(tmrTICK), .setREQ(setREQ),
        .aprFLAGS(f1), .aprINTREQ(r1), .aprINTR(i1)
    );

    function automatic logic [43:0] ex(input logic [7:0] fl, input logic rq, input logic [1:7] ir,
                                       input logic tp, input logic pg);
        logic [0:35] f;
        f = '0;
        f[33:35] = 3'b111;
        f[32] = rq;
        f[22] = tp;
        f[23] = pg;
        for (int i = 0; i < 8; i++) f[31-i] = fl[i];
        return {f, rq, ir};
    endfunction

    function automatic logic [43:0] obs(input bit d);
        return d ? {f1, r1, i1} : {f0, r0, i0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        {wrFLAGS, wrENABLE, wrTIMER, tmrTICK} = '0;
        setREQ = '0;
        dp = '0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    task automatic wr_en(input logic [7:0] en, input logic sw, input logic [2:0] pri,
                         input logic tp, input logic pg);
        dp = '0;
        for (int i = 0; i < 8; i++) dp[31-i] = en[i];
        dp[32] = sw;
        dp[33:35] = pri;
        dp[22] = tp;
        dp[23] = pg;
        wrENABLE = 1'b1;
        cyc();
        wrENABLE = 1'b0;
        dp = '0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            sb.push_back('{nm:"reset", d:d[0], v:ex(8'h00, 1'b0, 7'b0, 1'b0, 1'b0)});
            e = sb.pop_front(); o = obs(e.d); nvec++;
            if (o !== e.v) begin nerr++; $display("FAIL %s dut%0d: got %h exp %h", e.nm, e.d, o, e.v); end
        end
    endtask

    task automatic test_basic();
        rst_pulse();
        wr_en(8'h08, 1'b0, 3'd3, 1'b0, 1'b0);
        setREQ[3] = 1'b1;
        sb.push_back('{nm:"basic_set", d:0, v:ex(8'h08, 1'b1, 7'b0, 1'b0, 1'b0)});
        cyc();
        setREQ = '0;
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        sb.push_back('{nm:"basic_intr0", d:0, v:ex(8'h08, 1'b1, 7'b0010000, 1'b0, 1'b0)});
        sb.push_back('{nm:"basic_intr1", d:1, v:ex(8'h08, 1'b1, 7'b0010000, 1'b0, 1'b0)});
        cyc();
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front(); o = obs(e.d); nvec++;
            if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        end
        wrFLAGS = 1'b1;
        sb.push_back('{nm:"basic_clr", d:0, v:ex(8'h00, 1'b0, 7'b0010000, 1'b0, 1'b0)});
        cyc();
        wrFLAGS = 1'b0;
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        sb.push_back('{nm:"basic_drop", d:0, v:ex(8'h00, 1'b0, 7'b0, 1'b0, 1'b0)});
        cyc();
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
    endtask

    task automatic test_edge_w1c();
        logic [7:0] tbl_req[6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01};
        logic       tbl_wr [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] tbl_exp[6] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        rst_pulse();
        for (int t = 0; t < 6; t++) begin
            setREQ = tbl_req[t];
            wrFLAGS = tbl_wr[t];
            dp[31] = tbl_wr[t];
            sb.push_back('{nm:$sformatf("edge_w1c_%0d", t), d:1, v:ex(tbl_exp[t], 1'b0, 7'b0, 1'b0, 1'b0)});
            cyc();
            wrFLAGS = 1'b0;
            dp = '0;
            e = sb.pop_front(); o = obs(e.d); nvec++;
            if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        end
        setREQ = '0;
    endtask

    task automatic test_level_priority();
        rst_pulse();
        setREQ[2] = 1'b1;
        wrFLAGS = 1'b1;
        sb.push_back('{nm:"load_vs_set", d:0, v:ex(8'h04, 1'b0, 7'b0, 1'b0, 1'b0)});
        cyc();
        setREQ = '0;
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        sb.push_back('{nm:"load_clear", d:0, v:ex(8'h00, 1'b0, 7'b0, 1'b0, 1'b0)});
        cyc();
        wrFLAGS = 1'b0;
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        rst_pulse();
        setREQ[2] = 1'b1;
        dp[29] = 1'b1;
        wrFLAGS = 1'b1;
        sb.push_back('{nm:"w1c_vs_set", d:1, v:ex(8'h04, 1'b0, 7'b0, 1'b0, 1'b0)});
        cyc();
        setREQ = '0;
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        sb.push_back('{nm:"w1c_clear", d:1, v:ex(8'h00, 1'b0, 7'b0, 1'b0, 1'b0)});
        cyc();
        wrFLAGS = 1'b0;
        dp = '0;
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
    endtask

    task automatic test_timer();
        logic [0:11] rv;
        rst_pulse();
        tmrTICK = 1'b1;
        for (int t = 0; t < 3; t++) begin
            sb.push_back('{nm:"tmr_idle", d:0, v:ex(8'h00, 1'b0, 7'b0, 1'b0, 1'b0)});
            cyc();
            e = sb.pop_front(); o = obs(e.d); nvec++;
            if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        end
        rv = 12'd3;
        dp[24:35] = rv;
        wrTIMER = 1'b1;
        sb.push_back('{nm:"tmr_wr_wins", d:0, v:ex(8'h00, 1'b0, 7'b0, 1'b0, 1'b0)});
        cyc();
        wrTIMER = 1'b0;
        dp = '0;
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        for (int t = 1; t <= 6; t++) begin
            wrFLAGS = (t == 4);
            sb.push_back('{nm:$sformatf("tmr_tick%0d", t), d:0,
                           v:ex((t == 3 || t == 6) ? 8'h40 : 8'h00, 1'b0, 7'b0, 1'b0, 1'b0)});
            cyc();
            wrFLAGS = 1'b0;
            e = sb.pop_front(); o = obs(e.d); nvec++;
            if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        end
        tmrTICK = 1'b0;
    endtask

    task automatic test_swint();
        rst_pulse();
        wr_en(8'h00, 1'b1, 3'd0, 1'b0, 1'b0);
        sb.push_back('{nm:"sw_pri0", d:0, v:ex(8'h00, 1'b1, 7'b0, 1'b0, 1'b0)});
        cyc();
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        sb.push_back('{nm:"sw_pri7_lat", d:0, v:ex(8'h00, 1'b1, 7'b0, 1'b0, 1'b0)});
        wr_en(8'h00, 1'b1, 3'd7, 1'b0, 1'b0);
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        sb.push_back('{nm:"sw_pri7", d:0, v:ex(8'h00, 1'b1, 7'b0000001, 1'b0, 1'b0)});
        cyc();
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        sb.push_back('{nm:"sw_pri1_lat", d:0, v:ex(8'h00, 1'b1, 7'b0000001, 1'b0, 1'b0)});
        wr_en(8'h00, 1'b1, 3'd1, 1'b0, 1'b0);
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        sb.push_back('{nm:"sw_pri1", d:0, v:ex(8'h00, 1'b1, 7'b1000000, 1'b0, 1'b0)});
        cyc();
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
    endtask

    task automatic test_back_to_back();
        rst_pulse();
        dp[30] = 1'b1;
        dp[33:35] = 3'd2;
        dp[22] = 1'b1;
        wrFLAGS = 1'b1;
        wrENABLE = 1'b1;
        sb.push_back('{nm:"b2b_both", d:0, v:ex(8'h02, 1'b1, 7'b0, 1'b1, 1'b0)});
        cyc();
        {wrFLAGS, wrENABLE} = '0;
        dp = '0;
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        sb.push_back('{nm:"b2b_intr", d:0, v:ex(8'h02, 1'b1, 7'b0100000, 1'b1, 1'b0)});
        cyc();
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        clken = 1'b0;
        setREQ[5] = 1'b1;
        sb.push_back('{nm:"clken_hold", d:0, v:ex(8'h02, 1'b1, 7'b0100000, 1'b1, 1'b0)});
        cyc();
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        clken = 1'b1;
        sb.push_back('{nm:"clken_set", d:0, v:ex(8'h22, 1'b1, 7'b0100000, 1'b1, 1'b0)});
        cyc();
        setREQ = '0;
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
    endtask

    task automatic test_async_reset();
        logic [0:11] rv;
        rst_pulse();
        wr_en(8'hFF, 1'b0, 3'd5, 1'b1, 1'b1);
        rv = 12'd5;
        dp[24:35] = rv;
        wrTIMER = 1'b1;
        tmrTICK = 1'b1;
        setREQ[1] = 1'b1;
        cyc();
        wrTIMER = 1'b0;
        dp = '0;
        setREQ = '0;
        sb.push_back('{nm:"ar_active", d:0, v:ex(8'h02, 1'b1, 7'b0000100, 1'b1, 1'b1)});
        cyc();
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        #3;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            sb.push_back('{nm:"ar_immediate", d:d[0], v:ex(8'h00, 1'b0, 7'b0, 1'b0, 1'b0)});
            e = sb.pop_front(); o = obs(e.d); nvec++;
            if (o !== e.v) begin nerr++; $display("FAIL %s dut%0d: got %h exp %h", e.nm, e.d, o, e.v); end
        end
        setREQ = 8'hFF;
        sb.push_back('{nm:"ar_req_ignored", d:0, v:ex(8'h00, 1'b0, 7'b0, 1'b0, 1'b0)});
        cyc();
        e = sb.pop_front(); o = obs(e.d); nvec++;
        if (o !== e.v) begin nerr++; $display("FAIL %s: got %h exp %h", e.nm, o, e.v); end
        setREQ = '0;
        tmrTICK = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        repeat (2) cyc();
        test_reset();
        rst = 1'b1;
        test_basic();
        test_edge_w1c();
        test_level_priority();
        test_timer();
        test_swint();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
